// File: rtl/i2c_target.sv
// rtl/i2c_target.sv - I2C target endpoint with a fixed 7-bit address
//
// Purpose: oversamples SCL/SDA on clk and detects START and STOP. It matches
// and ACKs its own address, presents written bytes as single-cycle ticks and
// requests read bytes from local logic. SCL is never stretched.
//
// Optional build macro: GLITCH_FILTER_EN. When it is defined, a FILTER_LEN-sample
// majority filter is added on both lines after the synchronisers.
//
// Ports:
//   clk, rst_n   system clock (>= 20x SCL), asynchronous active-low reset
//   scl          I2C clock input (never driven)
//   sda          I2C data, open-drain (drives 0 or z only)
//   tx_data      read byte, sampled on the falling edge after tx_req
//   tx_req       pulse: next read byte needed
//   rx_data      last received write byte
//   rx_valid     pulse: rx_data updated
//   addr_hit     pulse: own address ACKed
//   rnw          R/W bit of the current transaction
//   start_det    pulse on START / repeated START
//   stop_det     pulse on STOP
//   busy         high from START to STOP
module i2c_target #(
  parameter logic [6:0] ADDR        = 7'h3C,
  parameter int         SYNC_STAGES = 2
`ifdef GLITCH_FILTER_EN
  , parameter int       FILTER_LEN  = 3
`endif
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scl,
  inout  wire        sda,
  input  logic [7:0] tx_data,
  output logic       tx_req,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       addr_hit,
  output logic       rnw,
  output logic       start_det,
  output logic       stop_det,
  output logic       busy
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_ADDR, ST_ADDR_ACK, ST_WR_BYTE, ST_WR_ACK, ST_RD_BYTE, ST_RD_ACK, ST_WAIT_STOP
  } state_t;

  state_t     state;
  logic [7:0] shreg;
  logic [2:0] bit_cnt;
  logic       sda_oe;
  logic       ack_seen;  // master ACKed in RD_ACK; load next byte on the coming fall

  assign sda = sda_oe ? 1'b0 : 1'bz;

  // Synchronisers preset to the idle bus level so reset release creates no events
  logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync <= '1;
      sda_sync <= '1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda};
    end
  end

  logic scl_s, sda_s;
`ifdef GLITCH_FILTER_EN
  logic [FILTER_LEN-1:0] scl_win, sda_win;
  logic                  scl_f, sda_f;

  function automatic logic majority(input logic [FILTER_LEN-1:0] w);
    int ones;
    ones = 0;
    for (int i = 0; i < FILTER_LEN; i++) ones += w[i] ? 1 : 0;
    return ones > FILTER_LEN / 2;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_win <= '1;
      sda_win <= '1;
      scl_f   <= 1'b1;
      sda_f   <= 1'b1;
    end else begin
      scl_win <= {scl_win[FILTER_LEN-2:0], scl_sync[SYNC_STAGES-1]};
      sda_win <= {sda_win[FILTER_LEN-2:0], sda_sync[SYNC_STAGES-1]};
      scl_f   <= majority(scl_win);
      sda_f   <= majority(sda_win);
    end
  end
  assign scl_s = scl_f;
  assign sda_s = sda_f;
`else
  assign scl_s = scl_sync[SYNC_STAGES-1];
  assign sda_s = sda_sync[SYNC_STAGES-1];
`endif

  logic scl_d, sda_d;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_d <= 1'b1;
      sda_d <= 1'b1;
    end else begin
      scl_d <= scl_s;
      sda_d <= sda_s;
    end
  end

  logic scl_rise, scl_fall, start_ev, stop_ev;
  assign scl_rise = scl_s & ~scl_d;
  assign scl_fall = ~scl_s & scl_d;
  assign start_ev = scl_s & scl_d & sda_d & ~sda_s;
  assign stop_ev  = scl_s & scl_d & ~sda_d & sda_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      shreg     <= 8'h00;
      bit_cnt   <= 3'd0;
      sda_oe    <= 1'b0;
      ack_seen  <= 1'b0;
      tx_req    <= 1'b0;
      rx_data   <= 8'h00;
      rx_valid  <= 1'b0;
      addr_hit  <= 1'b0;
      rnw       <= 1'b0;
      start_det <= 1'b0;
      stop_det  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      tx_req    <= 1'b0;
      rx_valid  <= 1'b0;
      addr_hit  <= 1'b0;
      start_det <= 1'b0;
      stop_det  <= 1'b0;
      if (start_ev) begin
        state     <= ST_ADDR;
        bit_cnt   <= 3'd7;
        busy      <= 1'b1;
        sda_oe    <= 1'b0;
        ack_seen  <= 1'b0;
        start_det <= 1'b1;
      end else if (stop_ev) begin
        state    <= ST_IDLE;
        busy     <= 1'b0;
        sda_oe   <= 1'b0;
        ack_seen <= 1'b0;
        stop_det <= 1'b1;
      end else begin
        case (state)
          ST_ADDR: if (scl_rise) begin
            shreg <= {shreg[6:0], sda_s};
            if (bit_cnt == 3'd0) begin
              // shreg[6:0] holds the address bits, sda_s is the R/W bit
              if (shreg[6:0] == ADDR && shreg[6:0] != 7'h00) begin
                rnw   <= sda_s;
                state <= ST_ADDR_ACK;
              end else begin
                state <= ST_WAIT_STOP;
              end
            end else begin
              bit_cnt <= bit_cnt - 3'd1;
            end
          end
          // sda_oe low marks the first fall (start ACK), high the second (end ACK)
          ST_ADDR_ACK: if (scl_fall) begin
            if (!sda_oe) begin
              sda_oe   <= 1'b1;
              addr_hit <= 1'b1;
            end else if (rnw) begin
              shreg   <= tx_data;
              sda_oe  <= ~tx_data[7];
              bit_cnt <= 3'd7;
              state   <= ST_RD_BYTE;
            end else begin
              sda_oe  <= 1'b0;
              bit_cnt <= 3'd7;
              state   <= ST_WR_BYTE;
            end
          end else if (scl_rise && sda_oe && rnw) begin
            tx_req <= 1'b1;
          end
          ST_WR_BYTE: if (scl_rise) begin
            shreg <= {shreg[6:0], sda_s};
            if (bit_cnt == 3'd0) begin
              rx_data  <= {shreg[6:0], sda_s};
              rx_valid <= 1'b1;
              state    <= ST_WR_ACK;
            end else begin
              bit_cnt <= bit_cnt - 3'd1;
            end
          end
          ST_WR_ACK: if (scl_fall) begin
            if (!sda_oe) begin
              sda_oe <= 1'b1;
            end else begin
              sda_oe  <= 1'b0;
              bit_cnt <= 3'd7;
              state   <= ST_WR_BYTE;
            end
          end
          ST_RD_BYTE: if (scl_fall) begin
            if (bit_cnt == 3'd0) begin
              sda_oe <= 1'b0;
              state  <= ST_RD_ACK;
            end else begin
              sda_oe  <= ~shreg[6];
              shreg   <= {shreg[6:0], 1'b0};
              bit_cnt <= bit_cnt - 3'd1;
            end
          end
          ST_RD_ACK: if (scl_rise) begin
            if (!sda_s) begin
              ack_seen <= 1'b1;
              tx_req   <= 1'b1;
            end else begin
              state <= ST_WAIT_STOP;
            end
          end else if (scl_fall && ack_seen) begin
            ack_seen <= 1'b0;
            shreg    <= tx_data;
            sda_oe   <= ~tx_data[7];
            bit_cnt  <= 3'd7;
            state    <= ST_RD_BYTE;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_target.sv
// tb/tb_i2c_target.sv - directed self-checking bench for i2c_target
`timescale 1ns/1ps
module tb_i2c_target;
  localparam int QT = 200;  // quarter SCL period: 10 clk, SCL = clk/40

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       scl = 1'b1;
  logic       m_oe = 1'b0;
  logic [7:0] tx_data = 8'h00;
  wire        sda;
  logic       tx_req, rx_valid, addr_hit, rnw, start_det, stop_det, busy;
  logic [7:0] rx_data;

  pullup (sda);
  assign sda = m_oe ? 1'b0 : 1'bz;

  i2c_target #(.ADDR(7'h3C), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .scl(scl), .sda(sda), .tx_data(tx_data),
    .tx_req(tx_req), .rx_data(rx_data), .rx_valid(rx_valid), .addr_hit(addr_hit),
    .rnw(rnw), .start_det(start_det), .stop_det(stop_det), .busy(busy)
  );

  always #10 clk = ~clk;

  int         n_hit = 0, n_rxv = 0, n_txr = 0, n_sta = 0, n_sto = 0, n_drv = 0;
  logic [7:0] rx_hist[$];
  logic       rnw_hist[$];

  always @(negedge clk) begin
    if (addr_hit) begin n_hit++; rnw_hist.push_back(rnw); end
    if (rx_valid) begin n_rxv++; rx_hist.push_back(rx_data); end
    if (tx_req) n_txr++;
    if (start_det) n_sta++;
    if (stop_det) n_sto++;
    if (sda === 1'b0 && !m_oe) n_drv++;
  end

  int errors = 0, checks = 0;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic bus_start();
    m_oe = 1'b0; #QT; scl = 1'b1; #QT; m_oe = 1'b1; #QT; scl = 1'b0; #QT;
  endtask
  task automatic bus_stop();
    m_oe = 1'b1; #QT; scl = 1'b1; #QT; m_oe = 1'b0; #QT;
  endtask
  task automatic bus_bit(input logic b, output logic s);
    m_oe = ~b; #QT; scl = 1'b1; #QT; s = sda; #QT; scl = 1'b0; #QT;
  endtask
  task automatic wr_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) bus_bit(b[i], s);
    bus_bit(1'b1, s);
    ack = ~s;
  endtask
  task automatic rd_byte(input logic m_ack, input logic [7:0] next_tx, output logic [7:0] b);
    logic s;
    for (int i = 7; i >= 0; i--) begin bus_bit(1'b1, s); b[i] = s; end
    tx_data = next_tx;
    bus_bit(~m_ack, s);
    m_oe = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       ack;
    logic [7:0] b;
    int         h0, r0, t0, s0, p0, d0, hh, rh;

    #55;
    chk("rst_outs", {tx_req, rx_valid, addr_hit, rnw, start_det, stop_det, busy}, 0);
    chk("rst_rx_data", rx_data, 8'h00);
    chk("rst_sda", sda, 1'b1);
    rst_n = 1'b1;
    #QT;

    // Write 0x78, 0xA5, 0x5A
    h0 = n_hit; r0 = n_rxv; p0 = n_sto; hh = rnw_hist.size(); rh = rx_hist.size();
    bus_start();
    chk("wr_busy", busy, 1'b1);
    wr_byte(8'h78, ack); chk("wr_addr_ack", ack, 1'b1);
    wr_byte(8'hA5, ack); chk("wr_d0_ack", ack, 1'b1);
    wr_byte(8'h5A, ack); chk("wr_d1_ack", ack, 1'b1);
    bus_stop(); #QT;
    chk("wr_hits", n_hit - h0, 1);
    chk("wr_rnw", rnw_hist[hh], 1'b0);
    chk("wr_rxv", n_rxv - r0, 2);
    chk("wr_rx0", rx_hist[rh], 8'hA5);
    chk("wr_rx1", rx_hist[rh+1], 8'h5A);
    chk("wr_stops", n_sto - p0, 1);
    chk("wr_busy_end", busy, 1'b0);

    // Read 0xC3 (ACK), 0x81 (NACK)
    t0 = n_txr; hh = rnw_hist.size();
    tx_data = 8'hC3;
    bus_start();
    wr_byte(8'h79, ack); chk("rd_addr_ack", ack, 1'b1);
    rd_byte(1'b1, 8'h81, b); chk("rd_b0", b, 8'hC3);
    rd_byte(1'b0, 8'h00, b); chk("rd_b1", b, 8'h81);
    #QT;
    chk("rd_sda_rel", sda, 1'b1);
    bus_stop(); #QT;
    chk("rd_txreq", n_txr - t0, 2);
    chk("rd_rnw", rnw_hist[hh], 1'b1);

    // Wrong address 0x7A
    h0 = n_hit; r0 = n_rxv; s0 = n_sta; p0 = n_sto; d0 = n_drv;
    bus_start();
    wr_byte(8'h7A, ack); chk("wa_addr_nack", ack, 1'b0);
    wr_byte(8'h11, ack);
    wr_byte(8'h22, ack);
    wr_byte(8'h00, ack); chk("wa_d2_nack", ack, 1'b0);
    bus_stop(); #QT;
    chk("wa_drive", n_drv - d0, 0);
    chk("wa_hits", n_hit - h0, 0);
    chk("wa_rxv", n_rxv - r0, 0);
    chk("wa_starts", n_sta - s0, 1);
    chk("wa_stops", n_sto - p0, 1);

    // Repeated START: write 0x10, Sr, read one byte with NACK
    r0 = n_rxv; s0 = n_sta; t0 = n_txr; hh = rnw_hist.size(); rh = rx_hist.size();
    bus_start();
    wr_byte(8'h78, ack);
    wr_byte(8'h10, ack); chk("rs_d_ack", ack, 1'b1);
    tx_data = 8'h5E;
    bus_start();
    wr_byte(8'h79, ack); chk("rs_addr_ack", ack, 1'b1);
    rd_byte(1'b0, 8'h00, b); chk("rs_rd", b, 8'h5E);
    bus_stop(); #QT;
    chk("rs_rxv", n_rxv - r0, 1);
    chk("rs_rx", rx_hist[rh], 8'h10);
    chk("rs_starts", n_sta - s0, 2);
    chk("rs_rnw0", rnw_hist[hh], 1'b0);
    chk("rs_rnw1", rnw_hist[hh+1], 1'b1);
    chk("rs_txreq", n_txr - t0, 1);

    // Abort: STOP after 4 data bits
    r0 = n_rxv; p0 = n_sto;
    bus_start();
    wr_byte(8'h78, ack);
    for (int i = 0; i < 4; i++) bus_bit(i[0], ack);
    bus_stop(); #QT;
    chk("ab_rxv", n_rxv - r0, 0);
    chk("ab_busy", busy, 1'b0);
    chk("ab_stop", n_sto - p0, 1);
    bus_start();
    wr_byte(8'h78, ack);
    wr_byte(8'h22, ack);
    bus_stop(); #QT;
    chk("ab_next_rx", rx_data, 8'h22);

    // Reset while the target drives a 0 bit of a read
    tx_data = 8'h00;
    bus_start();
    wr_byte(8'h79, ack);
    chk("rr_driving", sda, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("rr_sda_rel", sda, 1'b1);
    chk("rr_outs", {tx_req, rx_valid, addr_hit, rnw, start_det, stop_det, busy}, 0);
    chk("rr_rx_data", rx_data, 8'h00);
    #100;
    rst_n = 1'b1;
    #QT;
    h0 = n_hit;
    bus_start();
    wr_byte(8'h78, ack); chk("rr_addr_ack", ack, 1'b1);
    wr_byte(8'h33, ack);
    bus_stop(); #QT;
    chk("rr_rx", rx_data, 8'h33);
    chk("rr_hits", n_hit - h0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
